send_ack_initiator: RTL and testbench
=====================================

Name: send_ack_initiator

Overview:
- Transmitter end of the active-low Send/Ack token handshake used between peripheral stages.
- On a START request it latches a data word and drives a timed low pulse on Send_out. It then waits for the downstream stage's low pulse on Ack_in.
- It reports completion, timeout and a transfer count. It serves as the bench/board-side token injector that feeds a stage's Send_in and consumes its Ack_out.

Parameters:
- DATA_W, 8, width of the token data word.
- SEND_W, 2, Send_out low-pulse length in CLK cycles (range 1..15).
- TIMEOUT, 16, max CLK cycles spent in WAIT_ACK before error (range 2..255).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  transfer request, sampled every cycle; level or pulse.
- DATA_IN  in  DATA_W  word captured when START is accepted.
- Ack_in  in  1  active-low acknowledge from the downstream stage; asynchronous, idles 1.
- Send_out  out  1  active-low send strobe; idles 1.
- DATA_OUT  out  DATA_W  captured word, held stable from acceptance until the next acceptance.
- BUSY  out  1  high in SEND or WAIT_ACK.
- DONE  out  1  one-cycle pulse when the ack is received.
- TIMEOUT_ERR  out  1  sticky error, cleared by the next accepted START or by RST.
- SPURIOUS  out  1  sticky flag for an ack seen while IDLE, cleared by RST only.
- XFER_CNT  out  8  count of successful transfers; wraps 255->0.

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE, Send_out=1, DATA_OUT=0, BUSY=0, DONE=0, TIMEOUT_ERR=0, SPURIOUS=0, XFER_CNT=0.
  - Synchronizer flops reset to 1, so there is no false edge after reset.
  - RST mid-transfer aborts immediately. Send_out returns to 1 the same edge and the count is not incremented.
- Ack_in path:
  - Two-flop synchronizer (s1, s2) followed by an edge detector.
  - ack_fall=1 for exactly one cycle when s2 is 0 and was 1 the previous cycle.
  - A low level on Ack_in at edge k gives s1=0 at k and s2=0 at k+1, so ack_fall is high between k+1 and k+2.
  - Ack pulses narrower than one clock period are not guaranteed to be detected.
- State machine:
  - IDLE:
    - If START=1: capture DATA_IN into DATA_OUT, clear TIMEOUT_ERR, load the pulse counter with SEND_W, then go to SEND.
    - If ack_fall=1: set SPURIOUS.
    - If START and ack_fall coincide: accept START and set SPURIOUS.
  - SEND:
    - Send_out=0. Decrement the pulse counter each cycle.
    - If ack_fall occurs here, set the early_ack flag.
    - When the counter reaches 1: if early_ack or ack_fall, go to DONE_ST; otherwise go to WAIT_ACK and load the timeout counter with TIMEOUT.
    - Send_out is low for exactly SEND_W cycles, starting the cycle after START is accepted.
  - WAIT_ACK:
    - Send_out=1.
    - If ack_fall: go to DONE_ST.
    - Otherwise decrement the timeout counter. When it reaches 1 without an ack, set TIMEOUT_ERR and go to IDLE.
    - If ack_fall and timeout occur in the same cycle, the ack wins.
  - DONE_ST (1 cycle): DONE=1, XFER_CNT+=1 (mod 256), then go to IDLE. Send_out=1.
- START is ignored outside IDLE and is not queued. A START held high re-triggers on the first IDLE cycle after DONE_ST or a timeout. The minimum spacing between Send pulses is therefore SEND_W+2 cycles.
- All outputs are registered. No combinational path runs from an input to an output.

Decomposition:
- Shared package (handshake_pkg):
  - state encoding: IDLE, SEND, WAIT_ACK, DONE_ST;
  - SEND_LEVEL_ACTIVE=1'b0 and IDLE_LEVEL=1'b1 constants;
  - counter width constants.
- Sub-module sync_fall_detect:
  - ports: CLK, RST, async input, registered synced output, one-cycle fall pulse;
  - resets to 1;
  - reusable for Send_in on the receiver side.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, Ack_in=1 -> Send_out=1, XFER_CNT=0, BUSY=0, SPURIOUS=0, no DONE for 20 cycles.
- Normal transfer, SEND_W=2: START=1 for 1 cycle with DATA_IN=8'hA5; Ack_in low 1 cycle at 4 cycles after acceptance -> DATA_OUT=A5, Send_out low for exactly 2 cycles, DONE pulse once, XFER_CNT=1, BUSY low after DONE.
- Early ack: ack_fall occurs during SEND (SEND_W=4) -> no WAIT_ACK entry, DONE the cycle after SEND ends, XFER_CNT increments.
- Timeout: no ack, TIMEOUT=16 -> TIMEOUT_ERR=1 after 16 WAIT_ACK cycles, XFER_CNT unchanged. Next START clears TIMEOUT_ERR.
- Busy and spurious: START re-asserted during SEND -> ignored, exactly one Send pulse. Ack pulse in IDLE -> SPURIOUS=1, stays set until RST.
- Wrap and abort: 256 back-to-back transfers -> XFER_CNT wraps to 0. RST mid-SEND -> Send_out=1 next edge, no DONE.

Source files
------------

// File: rtl/handshake_pkg.sv
// handshake_pkg: state encoding, line levels and counter widths for the Send/Ack handshake
package handshake_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, DONE_ST} state_t;
    localparam logic SEND_LEVEL_ACTIVE = 1'b0;
    localparam logic IDLE_LEVEL        = 1'b1;
    localparam int   PCNT_W            = 4;
    localparam int   TCNT_W            = 8;
endpackage

// File: rtl/sync_fall_detect.sv
// sync_fall_detect: two-flop synchronizer for an idle-high line plus a one-cycle falling-edge pulse
module sync_fall_detect (
    input  logic CLK,
    input  logic RST,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);
    logic s1_q, s2_q, s3_q;
    // all flops reset high so releasing reset never looks like an edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end
    assign sync_o = s2_q;
    assign fall_o = ~s2_q & s3_q;
endmodule

// File: rtl/send_ack_initiator.sv
// send_ack_initiator: on START latches a word, drives a timed active-low Send pulse,
// then waits for the downstream Ack pulse, reporting done, timeout and a transfer count
module send_ack_initiator
    import handshake_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SEND_W  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              Ack_in,
    output logic              Send_out,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              TIMEOUT_ERR,
    output logic              SPURIOUS,
    output logic [7:0]        XFER_CNT
);
    localparam logic [PCNT_W-1:0] SEND_LOAD = PCNT_W'(SEND_W);
    localparam logic [TCNT_W-1:0] TOUT_LOAD = TCNT_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                early_q, early_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                spur_q, spur_d;
    logic [7:0]          xfer_q, xfer_d;
    logic                send_q, busy_q, done_q;
    logic                ack_fall, ack_sync_unused;

    sync_fall_detect u_ack_sync (
        .CLK     (CLK),
        .RST     (RST),
        .async_i (Ack_in),
        .sync_o  (ack_sync_unused),
        .fall_o  (ack_fall)
    );

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q;
        early_d = early_q;
        data_d  = data_q;
        err_d   = err_q;
        spur_d  = spur_q;
        case (state_q)
            IDLE: begin
                spur_d = spur_q | ack_fall;
                if (START) begin
                    state_d = SEND;
                    data_d  = DATA_IN;
                    err_d   = 1'b0;
                    pcnt_d  = SEND_LOAD;
                    early_d = 1'b0;
                end
            end
            SEND: begin
                early_d = early_q | ack_fall;
                pcnt_d  = pcnt_q - 1'b1;
                if (pcnt_q == 1) begin
                    state_d = (early_q | ack_fall) ? DONE_ST : WAIT_ACK;
                    tcnt_d  = TOUT_LOAD;
                end
            end
            WAIT_ACK: begin
                // an ack arriving on the last timeout cycle still completes the transfer
                if (ack_fall) begin
                    state_d = DONE_ST;
                end else if (tcnt_q == 1) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        xfer_d = xfer_q + 8'(state_d == DONE_ST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            early_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            spur_q  <= 1'b0;
            xfer_q  <= '0;
            send_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            tcnt_q  <= tcnt_d;
            early_q <= early_d;
            data_q  <= data_d;
            err_q   <= err_d;
            spur_q  <= spur_d;
            xfer_q  <= xfer_d;
            send_q  <= (state_d == SEND) ? SEND_LEVEL_ACTIVE : IDLE_LEVEL;
            busy_q  <= (state_d == SEND) || (state_d == WAIT_ACK);
            done_q  <= state_d == DONE_ST;
        end
    end

    assign Send_out    = send_q;
    assign DATA_OUT    = data_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = err_q;
    assign SPURIOUS    = spur_q;
    assign XFER_CNT    = xfer_q;
endmodule

// File: tb/tb_send_ack_initiator.sv
// tb_send_ack_initiator: directed vectors and corner sequences for the Send/Ack initiator
module tb_send_ack_initiator;
    logic       clk = 1'b0, rst = 1'b1;
    logic       start = 1'b0, ack = 1'b1, start1 = 1'b0, ack1 = 1'b1;
    logic [7:0] din = 8'h00;
    logic       send0, busy0, done0, err0, spur0;
    logic [7:0] dout0, cnt0;
    logic       send1, busy1, done1, err1, spur1;
    logic [7:0] dout1, cnt1;
    int         pass_cnt = 0, total = 0;

    send_ack_initiator #(.DATA_W(8), .SEND_W(2), .TIMEOUT(16)) u_dut (
        .CLK(clk), .RST(rst), .START(start), .DATA_IN(din), .Ack_in(ack),
        .Send_out(send0), .DATA_OUT(dout0), .BUSY(busy0), .DONE(done0),
        .TIMEOUT_ERR(err0), .SPURIOUS(spur0), .XFER_CNT(cnt0)
    );

    send_ack_initiator #(.DATA_W(8), .SEND_W(4), .TIMEOUT(16)) u_dut4 (
        .CLK(clk), .RST(rst), .START(start1), .DATA_IN(din), .Ack_in(ack1),
        .Send_out(send1), .DATA_OUT(dout1), .BUSY(busy1), .DONE(done1),
        .TIMEOUT_ERR(err1), .SPURIOUS(spur1), .XFER_CNT(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [7:0] data;
        logic       ack;
        logic       send, busy, done;
        logic [7:0] cnt, dout;
        logic       spur;
    } vec_t;
    vec_t vec[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dn, sl;
        // {start, data, ack | send, busy, done, cnt, dout, spur}
        vec[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'hA5, 1'b0};
        vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'hA5, 1'b0};
        vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'hA5, 1'b0};
        vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'hA5, 1'b0};
        vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'hA5, 1'b0};
        vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'hA5, 1'b0};
        vec[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'hA5, 1'b0};
        vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'hA5, 1'b0};
        vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'hA5, 1'b0};
        vec[9]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'h3C, 1'b0};
        vec[10] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'h3C, 1'b0};
        vec[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'h3C, 1'b0};
        vec[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'h3C, 1'b0};
        vec[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 8'h3C, 1'b0};
        vec[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'h3C, 1'b0};
        vec[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'h3C, 1'b0};
        vec[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'h3C, 1'b0};
        vec[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'h3C, 1'b1};

        // reset then idle
        rst = 1'b1;
        step;
        step;
        chk("rst send", 32'(send0), 32'd1);
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst done", 32'(done0), 32'd0);
        chk("rst err", 32'(err0), 32'd0);
        chk("rst spur", 32'(spur0), 32'd0);
        chk("rst cnt", 32'(cnt0), 32'd0);
        chk("rst dout", 32'(dout0), 32'd0);
        rst = 1'b0;
        dn = 0;
        sl = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (done0) dn++;
            if (!send0 || busy0) sl++;
        end
        chk("idle done pulses", 32'(dn), 32'd0);
        chk("idle send/busy activity", 32'(sl), 32'd0);

        // normal transfers, ignored START while busy, spurious ack in idle
        for (int i = 0; i < 18; i++) begin
            start = vec[i].start;
            din   = vec[i].data;
            ack   = vec[i].ack;
            step;
            chk($sformatf("v%0d send", i), 32'(send0), 32'(vec[i].send));
            chk($sformatf("v%0d busy", i), 32'(busy0), 32'(vec[i].busy));
            chk($sformatf("v%0d done", i), 32'(done0), 32'(vec[i].done));
            chk($sformatf("v%0d cnt", i), 32'(cnt0), 32'(vec[i].cnt));
            chk($sformatf("v%0d dout", i), 32'(dout0), 32'(vec[i].dout));
            chk($sformatf("v%0d spur", i), 32'(spur0), 32'(vec[i].spur));
            chk($sformatf("v%0d err", i), 32'(err0), 32'd0);
        end

        // timeout: 16 WAIT_ACK cycles without an ack
        start = 1'b1;
        din = 8'h5A;
        step;
        chk("to accept send", 32'(send0), 32'd0);
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 17; i++) begin
            step;
            if (done0) dn++;
        end
        chk("to busy before expiry", 32'(busy0), 32'd1);
        chk("to err before expiry", 32'(err0), 32'd0);
        step;
        if (done0) dn++;
        chk("to err", 32'(err0), 32'd1);
        chk("to busy", 32'(busy0), 32'd0);
        chk("to send", 32'(send0), 32'd1);
        chk("to cnt", 32'(cnt0), 32'd2);
        chk("to done pulses", 32'(dn), 32'd0);
        chk("to spur sticky", 32'(spur0), 32'd1);
        start = 1'b1;
        din = 8'hC3;
        step;
        chk("to err cleared", 32'(err0), 32'd0);
        chk("to dout", 32'(dout0), 32'hC3);
        start = 1'b0;
        ack = 1'b0;
        step;
        ack = 1'b1;
        step;
        step;
        chk("after to done", 32'(done0), 32'd1);
        chk("after to cnt", 32'(cnt0), 32'd3);
        step;

        // early ack on the SEND_W=4 instance
        start1 = 1'b1;
        din = 8'h42;
        step;
        chk("early send e0", 32'(send1), 32'd0);
        start1 = 1'b0;
        ack1 = 1'b0;
        step;
        ack1 = 1'b1;
        step;
        step;
        chk("early send e3", 32'(send1), 32'd0);
        chk("early busy e3", 32'(busy1), 32'd1);
        chk("early done e3", 32'(done1), 32'd0);
        step;
        chk("early done e4", 32'(done1), 32'd1);
        chk("early send e4", 32'(send1), 32'd1);
        chk("early busy e4", 32'(busy1), 32'd0);
        chk("early cnt", 32'(cnt1), 32'd1);
        chk("early dout", 32'(dout1), 32'h42);
        step;
        chk("early done e5", 32'(done1), 32'd0);

        // reset mid-SEND aborts
        start = 1'b1;
        din = 8'h77;
        step;
        chk("abort send low", 32'(send0), 32'd0);
        start = 1'b0;
        rst = 1'b1;
        step;
        chk("abort send", 32'(send0), 32'd1);
        chk("abort busy", 32'(busy0), 32'd0);
        chk("abort cnt", 32'(cnt0), 32'd0);
        chk("abort spur cleared", 32'(spur0), 32'd0);
        chk("abort dout", 32'(dout0), 32'd0);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (done0) dn++;
        end
        chk("abort done pulses", 32'(dn), 32'd0);

        // 256 back-to-back transfers with START held and an early ack each time
        start = 1'b1;
        din = 8'h11;
        dn = 0;
        for (int i = 0; i < 256; i++) begin
            ack = 1'b0;
            step;
            chk($sformatf("wrap %0d send", i), 32'(send0), 32'd0);
            ack = 1'b1;
            step;
            step;
            if (done0) dn++;
            if (i == 254) chk("wrap cnt 255", 32'(cnt0), 32'd255);
            step;
        end
        start = 1'b0;
        step;
        chk("wrap done pulses", 32'(dn), 32'd256);
        chk("wrap cnt", 32'(cnt0), 32'd0);
        chk("wrap spur", 32'(spur0), 32'd0);
        chk("wrap busy", 32'(busy0), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
